regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/cpu_pkg.sv | 16 +
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_mp_if.sv | 36 +++
 rtl/regfile_mp_scoreboard.sv | 30 +++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 218 +++++++++++++++++++++
 6 files changed

// File: rtl/cpu_pkg.sv
// CPU-wide shared widths: architectural word size and byte-lane helpers.
`ifndef FULLW
`define FULLW 32
`endif

package cpu_pkg;

    localparam int FULLW      = `FULLW;
    localparam int BYTE_W     = 8;
    localparam int BYTE_LANES = FULLW / BYTE_W;

    function automatic int lanes(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/regfile_mp_pkg.sv
// Register-file defaults and small elaboration helpers shared by regfile_mp and its bus interface.
package regfile_mp_pkg;

    import cpu_pkg::*;

    localparam int RF_ADDR_W = 4;
    localparam int RF_DATA_W = FULLW;
    localparam int RF_NUM_RD = 3;
    localparam int RF_NUM_WR = 2;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: read ports, byte-enabled write ports, scoreboard set and busy status.
interface regfile_mp_if
    import cpu_pkg::*;
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter int NUM_WR     = RF_NUM_WR
);

    localparam int NB    = lanes(DATA_WIDTH);
    localparam int DEPTH = rf_depth(ADDR_WIDTH);

    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic [NUM_WR*NB-1:0]         wr_be;
    logic                         sb_set;
    logic [ADDR_WIDTH-1:0]        sb_addr;
    logic [DEPTH-1:0]             busy;
    logic [NUM_RD-1:0]            rd_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_be, sb_set, sb_addr,
        input  rd_data, busy, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_be, sb_set, sb_addr,
        output rd_data, busy, rd_busy
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending bits: set by producer issue, cleared by any write to that register.
module reg_scoreboard #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] set_i,
    input  logic [DEPTH-1:0] clr_i,
    output logic [DEPTH-1:0] busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // A register issued and written back in the same cycle has a new producer in flight.
    always_comb begin
        busy_d = (busy_q & ~clr_i) | set_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with byte-lane writes, registered reads and a pending-bit scoreboard.
// Optional same-edge write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import cpu_pkg::*;
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter int NUM_WR     = RF_NUM_WR
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = rf_depth(ADDR_WIDTH);
    localparam int NB    = lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]        mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]        mem_d [DEPTH];
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_d;
    logic [DEPTH-1:0]             sb_set_vec;
    logic [DEPTH-1:0]             sb_clr_vec;
    logic [DEPTH-1:0]             busy;
    logic [NUM_RD-1:0]            rd_busy_d;

    // Ports are applied in ascending order so the higher-index port owns any shared lane.
    always_comb begin : write_merge
        mem_d = mem_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j]) begin
                for (int k = 0; k < NB; k++) begin
                    if (bus.wr_be[j*NB + k]) begin
                        mem_d[bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]][k*BYTE_W +: BYTE_W] =
                            bus.wr_data[j*DATA_WIDTH + k*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    always_comb begin : read_select
        rd_data_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
`ifdef REGFILE_BYPASS_EN
            rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_d[bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`else
            rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Any enabled write retires the pending producer, even with no byte lanes selected.
    always_comb begin : sb_vectors
        sb_set_vec = '0;
        sb_clr_vec = '0;
        if (bus.sb_set) begin
            sb_set_vec[bus.sb_addr] = 1'b1;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j]) begin
                sb_clr_vec[bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
    end

    reg_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_i  (sb_set_vec),
        .clr_i  (sb_clr_vec),
        .busy_o (busy)
    );

    always_comb begin : busy_lookup
        rd_busy_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_busy_d[i] = busy[bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.busy    = busy;
    assign bus.rd_busy = rd_busy_d;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp against a byte-array reference model.
module tb_regfile_mp;

    import cpu_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = FULLW;
    localparam int NR    = 3;
    localparam int NW    = 2;
    localparam int NBL   = BYTE_LANES;
    localparam int DEPTH = 16;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [7:0]    m_mem [DEPTH][NBL];
    bit            m_busy [DEPTH];
    logic [DW-1:0] exp_rd [NR];

    regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) ifc ();

    regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [DW-1:0] m_word(input int a);
        logic [DW-1:0] w;
        for (int k = 0; k < NBL; k++) w[k*8 +: 8] = m_mem[a][k];
        return w;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) begin
            m_busy[a] = 1'b0;
            for (int k = 0; k < NBL; k++) m_mem[a][k] = 8'h00;
        end
        for (int i = 0; i < NR; i++) exp_rd[i] = '0;
    endtask

    task automatic clear_inputs();
        ifc.rd_addr = '0;
        ifc.wr_en   = '0;
        ifc.wr_addr = '0;
        ifc.wr_data = '0;
        ifc.wr_be   = '0;
        ifc.sb_set  = 1'b0;
        ifc.sb_addr = '0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [DW-1:0] d, input logic [NBL-1:0] be);
        ifc.wr_en[j]              = 1'b1;
        ifc.wr_addr[j*AW +: AW]   = a[AW-1:0];
        ifc.wr_data[j*DW +: DW]   = d;
        ifc.wr_be[j*NBL +: NBL]   = be;
    endtask

    task automatic set_rd(input int i, input int a);
        ifc.rd_addr[i*AW +: AW] = a[AW-1:0];
    endtask

    // Advance one edge: predict from the model, then compare after the edge.
    task automatic cycle(input string tag);
        int               ra [NR];
        int               wa;
        logic [DEPTH-1:0] eb;
        logic [NR-1:0]    erb;
        for (int i = 0; i < NR; i++) ra[i] = int'(ifc.rd_addr[i*AW +: AW]);
        if (!BYP) for (int i = 0; i < NR; i++) exp_rd[i] = m_word(ra[i]);
        for (int j = 0; j < NW; j++) begin
            if (ifc.wr_en[j]) begin
                wa = int'(ifc.wr_addr[j*AW +: AW]);
                for (int k = 0; k < NBL; k++)
                    if (ifc.wr_be[j*NBL + k]) m_mem[wa][k] = ifc.wr_data[j*DW + k*8 +: 8];
                m_busy[wa] = 1'b0;
            end
        end
        if (ifc.sb_set) m_busy[int'(ifc.sb_addr)] = 1'b1;
        if (BYP) for (int i = 0; i < NR; i++) exp_rd[i] = m_word(ra[i]);
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s rd_data[%0d]", tag, i), ifc.rd_data[i*DW +: DW], exp_rd[i]);
        for (int a = 0; a < DEPTH; a++) eb[a] = m_busy[a];
        for (int i = 0; i < NR; i++) erb[i] = m_busy[ra[i]];
        chk({tag, " busy"}, 32'(ifc.busy), 32'(eb));
        chk({tag, " rd_busy"}, 32'(ifc.rd_busy), 32'(erb));
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s rd_data[%0d]", tag, i), ifc.rd_data[i*DW +: DW], 32'd0);
        chk({tag, " busy"}, 32'(ifc.busy), 32'd0);
        chk({tag, " rd_busy"}, 32'(ifc.rd_busy), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] want;
        int            wa;
        clear_inputs();
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // r3 full-word write, read back one cycle after the address
        clear_inputs(); set_wr(0, 3, 32'hDEADBEEF, 4'hF); cycle("w_r3");
        clear_inputs(); set_rd(0, 3); cycle("rd_r3");
        chk("r3_value", ifc.rd_data[31:0], 32'hDEADBEEF);

        // single byte lane from port 1
        clear_inputs(); set_wr(0, 5, 32'h11223344, 4'hF); cycle("w_r5");
        clear_inputs(); set_wr(1, 5, 32'h000000AA, 4'h1); cycle("w_r5_b0");
        clear_inputs(); set_rd(1, 5); cycle("rd_r5");
        chk("r5_byte_merge", ifc.rd_data[63:32], 32'h112233AA);

        // same-address collision, higher port owns shared lanes
        clear_inputs(); set_wr(0, 2, 32'hAAAAAAAA, 4'hF); set_wr(1, 2, 32'h55555555, 4'h3); cycle("w_r2");
        clear_inputs(); set_rd(2, 2); cycle("rd_r2");
        chk("r2_lane_priority", ifc.rd_data[95:64], 32'hAAAA5555);

        // read and write of r7 on the same edge
        clear_inputs(); set_wr(0, 7, 32'h1, 4'hF); cycle("w_r7");
        clear_inputs(); set_rd(0, 7); set_wr(0, 7, 32'h2, 4'hF); cycle("rw_r7");
        want = BYP ? 32'h2 : 32'h1;
        chk("r7_same_edge", ifc.rd_data[31:0], want);
        clear_inputs(); set_rd(0, 7); cycle("rd_r7");
        chk("r7_after", ifc.rd_data[31:0], 32'h2);

        // scoreboard set, clear by be=0 write, and set-wins collision
        clear_inputs(); set_rd(1, 4); ifc.sb_set = 1'b1; ifc.sb_addr = 4'd4;
        #1;
        chk("rd_busy_same_cycle", 32'(ifc.rd_busy[1]), 32'd0);
        cycle("sb_r4");
        chk("busy4_set", 32'(ifc.busy[4]), 32'd1);
        clear_inputs(); set_rd(1, 4); set_wr(0, 4, 32'hFFFFFFFF, 4'h0); cycle("clr_r4");
        chk("busy4_clear", 32'(ifc.busy[4]), 32'd0);
        clear_inputs(); set_rd(0, 4); cycle("rd_r4");
        chk("r4_be0_unchanged", ifc.rd_data[31:0], 32'd0);
        clear_inputs(); ifc.sb_set = 1'b1; ifc.sb_addr = 4'd4; set_wr(1, 4, 32'h123, 4'hF); cycle("sb_wr_r4");
        chk("busy4_set_wins", 32'(ifc.busy[4]), 32'd1);

        // randomized traffic, writes biased toward read addresses to hit collisions
        for (int n = 0; n < 300; n++) begin
            clear_inputs();
            for (int i = 0; i < NR; i++) set_rd(i, int'($urandom_range(0, DEPTH - 1)));
            for (int j = 0; j < NW; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    wa = ($urandom_range(0, 2) == 0) ? int'(ifc.rd_addr[AW-1:0])
                                                     : int'($urandom_range(0, DEPTH - 1));
                    set_wr(j, wa, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                ifc.sb_set  = 1'b1;
                ifc.sb_addr = 4'($urandom_range(0, DEPTH - 1));
            end
            cycle("rand");
        end

        // reset in the middle of a write burst
        clear_inputs(); set_wr(0, 9, $urandom, 4'hF); set_wr(1, 10, $urandom, 4'hF); cycle("burst0");
        clear_inputs(); set_wr(0, 11, $urandom, 4'hF); set_wr(1, 12, $urandom, 4'hF); cycle("burst1");
        clear_inputs(); set_wr(0, 13, $urandom, 4'hF); set_wr(1, 14, $urandom, 4'hF);
        ifc.sb_set = 1'b1; ifc.sb_addr = 4'd13;
        set_rd(0, 9); set_rd(1, 10); set_rd(2, 11);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_zero("mid_reset");
        @(posedge clk);
        #1;
        chk_zero("held_reset");
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < DEPTH; a++) begin
            clear_inputs();
            set_rd(0, a); set_rd(1, (a + 5) % DEPTH); set_rd(2, DEPTH - 1 - a);
            cycle("post_reset");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
